// File: rtl/game_tick_ctrl.sv
// rtl/game_tick_ctrl.sv - pong timing controller: pixel enable, game tick, match sequencing
//
// Ports:
//   clk_in     board clock; every strobe is derived from it
//   reset      synchronous active-high reset
//   start      pulse, begins a match from IDLE
//   pause_tgl  pulse, enters/leaves PAUSE
//   hit        pulse, paddle hit: shortens the tick period in RUN
//   score      pulse, point scored: back to SERVE at base speed
//   pix_en     one-cycle strobe every PIX_DIV cycles
//   game_tick  one-cycle strobe every period cycles, RUN only
//   period     current game-tick period in clk_in cycles
//   state      0=IDLE 1=SERVE 2=RUN 3=PAUSE
//   running    high while state is RUN
module game_tick_ctrl #(
    parameter int PIX_DIV     = 4,
    parameter int BASE_PERIOD = 1666666,
    parameter int MIN_PERIOD  = 416666,
    parameter int STEP        = 104166,
    parameter int SERVE_TICKS = 60,
    parameter int CNT_W       = 21
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             pause_tgl,
    input  logic             hit,
    input  logic             score,
    output logic             pix_en,
    output logic             game_tick,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       state,
    output logic             running
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam int PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int SRV_W = $clog2(SERVE_TICKS + 1);

    localparam logic [CNT_W-1:0] C_BASE     = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] C_MIN      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] C_STEP     = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [PIX_W-1:0] C_PIX_LAST = PIX_W'(PIX_DIV - 1);
    localparam logic [PIX_W-1:0] C_PIX_ONE  = PIX_W'(1);
    localparam logic [SRV_W-1:0] C_SERVE    = SRV_W'(SERVE_TICKS);
    localparam logic [SRV_W-1:0] C_SRV_ONE  = SRV_W'(1);

    state_t           r_state;
    state_t           r_ret;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [SRV_W-1:0] r_serve_cnt;
    logic             r_running;

    state_t           w_state_nxt;
    state_t           w_ret_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [SRV_W-1:0] w_serve_nxt;
    logic             w_tick;
    logic             w_last_serve;
    logic [CNT_W-1:0] w_cnt_step;
    logic [CNT_W-1:0] w_cnt_hold;
    logic [CNT_W-1:0] w_hit_period;

    // >= rather than == so a period shortened below the running count
    // still produces a tick instead of waiting for a counter wrap.
    assign w_tick       = ((r_state == S_SERVE) || (r_state == S_RUN)) &&
                          (r_cnt >= (r_period - C_ONE));
    assign w_last_serve = w_tick && (r_serve_cnt == C_SRV_ONE);
    assign w_cnt_step   = w_tick ? '0 : (r_cnt + C_ONE);
    // On entering PAUSE the count freezes, but a tick fired in that same
    // cycle is consumed so it is not emitted a second time on resume.
    assign w_cnt_hold   = w_tick ? '0 : r_cnt;
    assign w_hit_period = (32'(r_period) < 32'(MIN_PERIOD + STEP)) ? C_MIN
                                                                   : (r_period - C_STEP);

    always_comb begin
        w_state_nxt  = r_state;
        w_ret_nxt    = r_ret;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_serve_nxt  = r_serve_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt  = S_SERVE;
                    w_serve_nxt  = C_SERVE;
                    w_period_nxt = C_BASE;
                end
            end
            S_SERVE: begin
                if (w_tick) begin
                    w_serve_nxt = r_serve_cnt - C_SRV_ONE;
                end
                if (pause_tgl) begin
                    w_state_nxt = S_PAUSE;
                    w_ret_nxt   = w_last_serve ? S_RUN : S_SERVE;
                    w_cnt_nxt   = w_cnt_hold;
                end else begin
                    w_cnt_nxt = w_cnt_step;
                    if (w_last_serve) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (score) begin
                    w_state_nxt  = S_SERVE;
                    w_period_nxt = C_BASE;
                    w_cnt_nxt    = '0;
                    w_serve_nxt  = C_SERVE;
                end else if (pause_tgl) begin
                    w_state_nxt = S_PAUSE;
                    w_ret_nxt   = S_RUN;
                    w_cnt_nxt   = w_cnt_hold;
                end else begin
                    // A tick in the hit cycle already fired on the old period.
                    w_cnt_nxt = w_cnt_step;
                    if (hit) begin
                        w_period_nxt = w_hit_period;
                    end
                end
            end
            S_PAUSE: begin
                if (pause_tgl) begin
                    w_state_nxt = r_ret;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ret       <= S_SERVE;
            r_pix_cnt   <= '0;
            r_cnt       <= '0;
            r_period    <= C_BASE;
            r_serve_cnt <= '0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret       <= w_ret_nxt;
            r_pix_cnt   <= (r_pix_cnt == C_PIX_LAST) ? '0 : (r_pix_cnt + C_PIX_ONE);
            r_cnt       <= w_cnt_nxt;
            r_period    <= w_period_nxt;
            r_serve_cnt <= w_serve_nxt;
            r_running   <= (w_state_nxt == S_RUN);
        end
    end

    // Strobes are masked while reset is held so nothing fires in the reset cycle.
    assign pix_en    = !reset && (r_pix_cnt == C_PIX_LAST);
    assign game_tick = !reset && w_tick && (r_state == S_RUN);
    assign period    = r_period;
    assign state     = r_state;
    assign running   = r_running;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// tb/tb_game_tick_ctrl.sv - directed table, pixel sequence and randomized model checks for game_tick_ctrl
module tb_game_tick_ctrl;

    localparam int PIX_DIV     = 4;
    localparam int BASE_PERIOD = 20;
    localparam int MIN_PERIOD  = 8;
    localparam int STEP        = 5;
    localparam int SERVE_TICKS = 2;
    localparam int CNT_W       = 8;

    logic             clk_in = 1'b0;
    logic             reset, start, pause_tgl, hit, score;
    logic             pix_en, game_tick, running;
    logic [CNT_W-1:0] period;
    logic [1:0]       state;

    game_tick_ctrl #(
        .PIX_DIV(PIX_DIV), .BASE_PERIOD(BASE_PERIOD), .MIN_PERIOD(MIN_PERIOD),
        .STEP(STEP), .SERVE_TICKS(SERVE_TICKS), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .reset(reset), .start(start), .pause_tgl(pause_tgl),
        .hit(hit), .score(score), .pix_en(pix_en), .game_tick(game_tick),
        .period(period), .state(state), .running(running)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: match state as plain integers; pixel phase from cycle count.
    int m_st = 0, m_ret = 1, m_per = BASE_PERIOD, m_cnt = 0, m_serve = 0, m_cyc = 0;

    task automatic model_edge(input bit rst, input bit st, input bit pt, input bit ht, input bit sc);
        bit tk;
        if (rst) begin
            m_st = 0; m_ret = 1; m_per = BASE_PERIOD; m_cnt = 0; m_serve = 0; m_cyc = 0;
            return;
        end
        m_cyc++;
        tk = (m_st == 1 || m_st == 2) && (m_cnt >= m_per - 1);
        case (m_st)
            0: if (st) begin m_st = 1; m_serve = SERVE_TICKS; m_per = BASE_PERIOD; m_cnt = 0; end
            1: begin
                if (pt) begin
                    m_ret = (tk && m_serve == 1) ? 2 : 1;
                    m_st  = 3;
                    if (tk) begin m_serve--; m_cnt = 0; end
                end else if (tk) begin
                    if (m_serve == 1) m_st = 2;
                    m_serve--;
                    m_cnt = 0;
                end else m_cnt++;
            end
            2: begin
                if (sc) begin
                    m_st = 1; m_per = BASE_PERIOD; m_cnt = 0; m_serve = SERVE_TICKS;
                end else if (pt) begin
                    m_ret = 2; m_st = 3;
                    if (tk) m_cnt = 0;
                end else begin
                    m_cnt = tk ? 0 : m_cnt + 1;
                    if (ht) m_per = (m_per < MIN_PERIOD + STEP) ? MIN_PERIOD : m_per - STEP;
                end
            end
            default: if (pt) m_st = m_ret;
        endcase
    endtask

    bit chk_model = 0;
    int gt_seen, pix_seen;
    bit last_pix;

    // Drive one cycle, sample combinational strobes mid-cycle, advance across the edge.
    task automatic cycle(input bit rst, input bit st, input bit pt, input bit ht, input bit sc);
        int e_gt, e_pix;
        reset = rst; start = st; pause_tgl = pt; hit = ht; score = sc;
        #4;
        gt_seen  += int'(game_tick);
        pix_seen += int'(pix_en);
        last_pix = pix_en;
        if (chk_model) begin
            e_gt  = (!rst && m_st == 2 && m_cnt >= m_per - 1) ? 1 : 0;
            e_pix = (!rst && (m_cyc % PIX_DIV) == PIX_DIV - 1) ? 1 : 0;
            chk($sformatf("rnd game_tick cyc%0d", m_cyc), int'(game_tick), e_gt);
            chk($sformatf("rnd pix_en cyc%0d", m_cyc), int'(pix_en), e_pix);
            chk($sformatf("rnd state cyc%0d", m_cyc), int'(state), m_st);
            chk($sformatf("rnd period cyc%0d", m_cyc), int'(period), m_per);
            chk($sformatf("rnd running cyc%0d", m_cyc), int'(running), (m_st == 2) ? 1 : 0);
        end
        model_edge(rst, st, pt, ht, sc);
        @(posedge clk_in);
        #1;
    endtask

    typedef struct {
        bit rst, st, pt, ht, sc;
        int n;
        int e_state, e_period, e_gt, e_pix;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit st, input bit pt, input bit ht, input bit sc,
                       input int n, input int es, input int ep, input int eg, input int ex);
        vec_t v;
        v.rst = rst; v.st = st; v.pt = pt; v.ht = ht; v.sc = sc;
        v.n = n; v.e_state = es; v.e_period = ep; v.e_gt = eg; v.e_pix = ex;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause_tgl = 1'b0; hit = 1'b0; score = 1'b0;

        //   rst st pt ht sc   n  state per gt pix
        add(1, 0, 0, 0, 0,   1,  0, 20, 0, 0);   // reset
        add(0, 0, 0, 0, 0,  40,  0, 20, 0, 10);  // idle: pix at 3,7,..,39
        add(0, 0, 1, 1, 1,   1,  0, 20, 0, -1);  // IDLE ignores others
        add(0, 1, 0, 0, 0,   1,  1, 20, 0, -1);  // start -> SERVE
        add(0, 0, 0, 0, 0,  39,  1, 20, 0, -1);
        add(0, 0, 0, 0, 0,   1,  2, 20, 0, -1);  // 40th SERVE cycle -> RUN
        add(0, 0, 0, 0, 0,  20,  2, 20, 1, -1);  // tick on 20th RUN cycle
        add(0, 0, 0, 1, 0,  30,  2, 15, 2, -1);
        add(0, 0, 0, 1, 0,  30,  2, 10, 3, -1);
        add(0, 0, 0, 1, 0,  30,  2,  8, 3, -1);  // clamped
        add(0, 0, 0, 1, 0,  10,  2,  8, 2, -1);  // stays at MIN
        add(0, 0, 0, 0, 1,   1,  1, 20, 0, -1);  // score -> SERVE
        add(0, 0, 0, 0, 0,  40,  2, 20, 0, -1);
        add(0, 0, 0, 0, 0,  20,  2, 20, 1, -1);
        add(0, 0, 0, 0, 0,  12,  2, 20, 0, -1);  // cnt = 12
        add(0, 0, 1, 0, 0,   1,  3, 20, 0, -1);  // pause
        add(0, 0, 0, 0, 0, 100,  3, 20, 0, 25);  // frozen, pix runs
        add(0, 0, 1, 0, 0,   1,  2, 20, 0, -1);  // resume
        add(0, 0, 0, 0, 0,   7,  2, 20, 0, -1);
        add(0, 0, 0, 0, 0,   1,  2, 20, 1, -1);  // 8th cycle after resume
        add(0, 0, 0, 1, 0,  14,  2, 15, 0, -1);  // tick now pending
        add(1, 0, 0, 0, 0,   1,  0, 20, 0, 0);   // reset swallows tick
        add(0, 1, 0, 0, 0,   1,  1, 20, 0, -1);
        add(0, 0, 0, 1, 0,   1,  1, 20, 0, -1);  // hit ignored in SERVE
        add(0, 0, 0, 0, 0,  39,  2, 20, 0, -1);
        add(0, 0, 0, 1, 0,   1,  2, 15, 0, -1);
        add(0, 0, 1, 0, 1,   1,  1, 20, 0, -1);  // score beats pause
        add(0, 0, 1, 0, 0,   1,  3, 20, 0, -1);  // pause from SERVE
        add(0, 0, 0, 0, 1,   1,  3, 20, 0, -1);
        add(0, 0, 0, 1, 0,   1,  3, 20, 0, -1);
        add(0, 1, 0, 0, 0,   1,  3, 20, 0, -1);
        add(0, 0, 1, 0, 0,   1,  1, 20, 0, -1);  // back to SERVE
        add(0, 1, 0, 0, 0,   1,  1, 20, 0, -1);  // start ignored

        @(posedge clk_in);
        #1;

        foreach (tbl[r]) begin
            gt_seen = 0; pix_seen = 0;
            for (int c = 0; c < tbl[r].n; c++) begin
                if (c == 0) cycle(tbl[r].rst, tbl[r].st, tbl[r].pt, tbl[r].ht, tbl[r].sc);
                else        cycle(0, 0, 0, 0, 0);
            end
            chk($sformatf("row%0d state", r), int'(state), tbl[r].e_state);
            chk($sformatf("row%0d period", r), int'(period), tbl[r].e_period);
            chk($sformatf("row%0d running", r), int'(running), (tbl[r].e_state == 2) ? 1 : 0);
            chk($sformatf("row%0d game_ticks", r), gt_seen, tbl[r].e_gt);
            if (tbl[r].e_pix >= 0) chk($sformatf("row%0d pix_ens", r), pix_seen, tbl[r].e_pix);
        end

        // Exact pix_en phase after reset release.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 0, 0, 0);
            chk($sformatf("pix_en phase %0d", i), int'(last_pix), (i % PIX_DIV == PIX_DIV - 1) ? 1 : 0);
        end

        // Randomized traffic against the reference model.
        cycle(1, 0, 0, 0, 0);
        chk_model = 1;
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 499) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 59) == 0);
        end
        chk_model = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
